// File: rtl/bitpack_if.sv
// rtl/bitpack_if.sv - field-in / word-out handshake bundle for the bit packer
//
// Purpose: groups the producer-side field stream and the memory-side word
// stream of bitpack into one interface.
//   in_valid/in_ready  field handshake
//   in_bits[15:0]      field value, LSB-aligned
//   in_len[3:0]        field length minus 1
//   in_last            field closes the packet
//   out_valid/out_ready word handshake
//   out_data[15:0]     packed word, first field in the MSBs
//   out_fill[4:0]      meaningful bits counted from bit 15 down
//   out_last           final word of the packet
// Modports: master = field producer / word consumer, slave = packer.

interface bitpack_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bits;
  logic [3:0]  in_len;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_fill;
  logic        out_last;

  modport master (
    output in_valid, in_bits, in_len, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_fill, out_last
  );

  modport slave (
    input  in_valid, in_bits, in_len, in_last, out_ready,
    output in_ready, out_valid, out_data, out_fill, out_last
  );
endinterface

// File: rtl/bitpack.sv
// rtl/bitpack.sv - variable-width MSB-first bit packer into 16-bit words
//
// Purpose: concatenates LSB-aligned fields of 1..16 bits MSB-first into a
// stream of 16-bit words; a packet-final field zero-pads and flushes the
// residual bits.
// Ports:
//   clk      system clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      bitpack_if.slave: field input stream and word output stream

module bitpack (
  input  logic       clk,
  input  logic       reset_n,
  bitpack_if.slave   bus
);

  // Accumulator: valid bits occupy acc[31 -: cnt]; everything below is zero.
  logic [31:0] acc, acc_nx;
  logic [5:0]  cnt, cnt_nx;
  logic        last_pend, last_pend_nx;

  // One-deep output register.
  logic        valid_q, valid_nx;
  logic [15:0] data_q, data_nx;
  logic [4:0]  fill_q, fill_nx;
  logic        last_q, last_nx;

  logic        in_ready_w;
  logic        out_free;
  logic        accept;
  logic        emit_full;
  logic        emit_flush;
  logic [4:0]  len_ext;
  logic [31:0] mask;
  logic [31:0] field;
  logic [5:0]  shamt;

  // Ready depends on registered state only, so producers never see a
  // combinational path from their own valid or from out_ready.
  assign in_ready_w = (cnt < 6'd16) && !last_pend;
  assign out_free   = !valid_q || bus.out_ready;

  assign accept     = bus.in_valid && in_ready_w;
  assign emit_full  = (cnt >= 6'd16) && out_free;
  assign emit_flush = last_pend && (cnt != 6'd0) && (cnt < 6'd16) && out_free;

  assign len_ext = {1'b0, bus.in_len} + 5'd1;
  assign mask    = (32'd1 << len_ext) - 32'd1;
  assign field   = {16'd0, bus.in_bits} & mask;
  // Place the field right under the bits already held. With cnt <= 15 and
  // len <= 16 on an accept this is always 1..31, so nothing falls off.
  assign shamt   = 6'd32 - cnt - {1'b0, len_ext};

  always_comb begin
    acc_nx       = acc;
    cnt_nx       = cnt;
    last_pend_nx = last_pend;
    data_nx      = data_q;
    fill_nx      = fill_q;
    last_nx      = last_q;
    valid_nx     = valid_q && !bus.out_ready;

    // Accept needs cnt < 16 and no pending last; both emits need either
    // cnt >= 16 or a pending last, so at most one branch is live.
    if (accept) begin
      acc_nx = acc | (field << shamt);
      cnt_nx = cnt + {1'b0, len_ext};
      if (bus.in_last) begin
        last_pend_nx = 1'b1;
      end
    end else if (emit_full) begin
      data_nx  = acc[31:16];
      fill_nx  = 5'd16;
      acc_nx   = acc << 16;
      cnt_nx   = cnt - 6'd16;
      last_nx  = last_pend && (cnt == 6'd16);
      valid_nx = 1'b1;
      if (last_pend && (cnt == 6'd16)) begin
        last_pend_nx = 1'b0;
      end
    end else if (emit_flush) begin
      // Bits below cnt are already zero, so the word is self-padded.
      data_nx      = acc[31:16];
      fill_nx      = cnt[4:0];
      last_nx      = 1'b1;
      valid_nx     = 1'b1;
      acc_nx       = 32'd0;
      cnt_nx       = 6'd0;
      last_pend_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= 32'd0;
      cnt       <= 6'd0;
      last_pend <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= 16'd0;
      fill_q    <= 5'd0;
      last_q    <= 1'b0;
    end else begin
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      last_pend <= last_pend_nx;
      valid_q   <= valid_nx;
      data_q    <= data_nx;
      fill_q    <= fill_nx;
      last_q    <= last_nx;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_fill  = fill_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_bitpack.sv
// tb/tb_bitpack.sv - self-checking bench for bitpack

module tb_bitpack;

  logic clk;
  logic reset_n;

  bitpack_if bus();

  bitpack dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  fill;
    logic        last;
  } word_t;

  typedef struct {
    logic [3:0]  len;
    logic [15:0] bits;
    logic        last;
    bit          has_word;
    logic [15:0] exp_data;
    logic [4:0]  exp_fill;
    logic        exp_last;
    logic [5:0]  exp_cnt;
  } vec_t;

  int    n_cmp  = 0;
  int    n_fail = 0;
  word_t got_q[$];
  word_t exp_q[$];
  bit    mq[$];
  bit    model_en = 1'b0;
  bit    rand_done = 1'b0;
  vec_t  tbl[$];

  // Every completed output handshake.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready)
      got_q.push_back('{data: bus.out_data, fill: bus.out_fill, last: bus.out_last});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: the packet as a plain bit sequence, cut into 16-bit words.
  task automatic model_push(input logic [3:0] len, input logic [15:0] bits, input logic last);
    word_t w;
    int    n;
    for (int b = int'(len); b >= 0; b--) mq.push_back(bits[b]);
    while (mq.size() >= 16) begin
      w.data = 16'd0;
      for (int i = 0; i < 16; i++) w.data = {w.data[14:0], mq.pop_front()};
      w.fill = 5'd16;
      w.last = last && (mq.size() == 0);
      exp_q.push_back(w);
    end
    if (last && mq.size() > 0) begin
      n = mq.size();
      w.data = 16'd0;
      for (int i = 0; i < n; i++) w.data[15-i] = mq.pop_front();
      w.fill = 5'(n);
      w.last = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send_field(input logic [3:0] len, input logic [15:0] bits, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_len   = len;
    bus.in_bits  = bits;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (model_en) model_push(len, bits, last);
    end
  endtask

  // Returns at posedge+1.
  task automatic wait_word(output word_t w, output bit ok);
    ok = 1'b0;
    w  = '0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); #1;
      if (got_q.size() > 0) begin
        w  = got_q.pop_front();
        ok = 1'b1;
      end
    end
    if (!ok) check("word_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w;
    bit    ok;
    int    lows;

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bits   = 16'd0;
    bus.in_len    = 4'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_out_fill",  32'(bus.out_fill),  32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);

    // ---- Table-driven directed vectors --------------------------------
    tbl.push_back('{4'd3,  16'h000A, 1'b0, 1'b0, 16'h0000, 5'd0,  1'b0, 6'd0});
    tbl.push_back('{4'd3,  16'h000B, 1'b0, 1'b0, 16'h0000, 5'd0,  1'b0, 6'd0});
    tbl.push_back('{4'd3,  16'h000C, 1'b0, 1'b0, 16'h0000, 5'd0,  1'b0, 6'd0});
    tbl.push_back('{4'd3,  16'h000D, 1'b0, 1'b1, 16'hABCD, 5'd16, 1'b0, 6'd0});
    tbl.push_back('{4'd11, 16'h0FFF, 1'b0, 1'b0, 16'h0000, 5'd0,  1'b0, 6'd0});
    tbl.push_back('{4'd7,  16'h005A, 1'b0, 1'b1, 16'hFFF5, 5'd16, 1'b0, 6'd4});
    tbl.push_back('{4'd3,  16'h0003, 1'b1, 1'b1, 16'hA300, 5'd8,  1'b1, 6'd0});
    tbl.push_back('{4'd2,  16'h0005, 1'b1, 1'b1, 16'hA000, 5'd3,  1'b1, 6'd0});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{4'd0, 16'hFFFF, 1'b0, (i == 15), 16'hFFFF, 5'd16, 1'b0, 6'd0});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{4'd0, 16'hFFFE, 1'b0, (i == 15), 16'h0000, 5'd16, 1'b0, 6'd0});
    // Garbage above the length must not leak: 0xF3 as 4 bits is 0x3.
    tbl.push_back('{4'd3,  16'hFFF3, 1'b0, 1'b0, 16'h0000, 5'd0,  1'b0, 6'd0});
    tbl.push_back('{4'd7,  16'hAB12, 1'b1, 1'b1, 16'h3120, 5'd12, 1'b1, 6'd0});

    for (int i = 0; i < tbl.size(); i++) begin
      send_field(tbl[i].len, tbl[i].bits, tbl[i].last);
      if (tbl[i].has_word) begin
        wait_word(w, ok);
        if (ok) begin
          check($sformatf("tbl%0d_data", i), 32'(w.data), 32'(tbl[i].exp_data));
          check($sformatf("tbl%0d_fill", i), 32'(w.fill), 32'(tbl[i].exp_fill));
          check($sformatf("tbl%0d_last", i), 32'(w.last), 32'(tbl[i].exp_last));
          check($sformatf("tbl%0d_cnt", i),  32'(dut.cnt), 32'(tbl[i].exp_cnt));
        end
      end
    end
    repeat (3) @(posedge clk); #1;
    check("tbl_no_extra_words", 32'(got_q.size()), 32'd0);

    // ---- Bubble and latency on a full word ------------------------------
    got_q.delete();
    send_field(4'd3, 16'hA, 1'b0);
    send_field(4'd3, 16'hB, 1'b0);
    send_field(4'd3, 16'hC, 1'b0);
    send_field(4'd3, 16'hD, 1'b0);
    lows = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (!bus.in_ready) lows++;
      if (c == 0) check("lat_not_yet_valid", 32'(bus.out_valid), 32'd0);
      if (c == 1) begin
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        check("lat_data",  32'(bus.out_data),  32'hABCD);
      end
    end
    check("bubble_cycles", 32'(lows), 32'd1);
    @(posedge clk); #1;
    got_q.delete();

    // ---- Single short last field: in_ready held until the word loads ----
    send_field(4'd2, 16'h5, 1'b1);
    @(negedge clk);
    check("last_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("last_ready_back", 32'(bus.in_ready), 32'd1);
    check("last_word", {10'd0, bus.out_data, bus.out_fill, bus.out_last},
          {10'd0, 16'hA000, 5'd3, 1'b1});
    @(posedge clk); #1;
    got_q.delete();

    // ---- Backpressure --------------------------------------------------
    bus.out_ready = 1'b0;
    send_field(4'd15, 16'h1234, 1'b0);
    send_field(4'd15, 16'h5678, 1'b0);
    fork
      send_field(4'd15, 16'h9ABC, 1'b0);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("bp_valid", 32'(bus.out_valid), 32'd1);
          check("bp_hold",  32'(bus.out_data),  32'h1234);
          check("bp_ready", 32'(bus.in_ready),  32'd0);
          check("bp_cnt",   32'(dut.cnt),       32'd16);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_word(w, ok);
    if (ok) check("bp_w0", 32'(w.data), 32'h1234);
    wait_word(w, ok);
    if (ok) check("bp_w1", 32'(w.data), 32'h5678);
    wait_word(w, ok);
    if (ok) check("bp_w2", 32'(w.data), 32'h9ABC);

    // ---- Reset mid-packet ---------------------------------------------
    got_q.delete();
    bus.out_ready = 1'b0;
    send_field(4'd15, 16'h1234, 1'b0);
    send_field(4'd11, 16'h0ABC, 1'b0);
    @(negedge clk);
    check("pre_rst_cnt",   32'(dut.cnt),       32'd12);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_outputs", {9'd0, bus.in_ready, bus.out_valid, bus.out_data, bus.out_fill, bus.out_last},
          {9'd0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0});
    check("arst_cnt", 32'(dut.cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send_field(4'd3, 16'h1, 1'b0);
    send_field(4'd3, 16'h2, 1'b0);
    send_field(4'd3, 16'h3, 1'b0);
    send_field(4'd3, 16'h4, 1'b0);
    wait_word(w, ok);
    if (ok) check("post_rst_word", {10'd0, w}, {10'd0, 16'h1234, 5'd16, 1'b0});
    repeat (3) @(posedge clk); #1;
    check("post_rst_no_partial", 32'(got_q.size()), 32'd0);

    // ---- Randomized against the bit-queue model -------------------------
    got_q.delete();
    exp_q.delete();
    mq.delete();
    model_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 250; i++)
          send_field(4'($urandom_range(0, 15)), 16'($urandom),
                     (i == 249) || ($urandom_range(0, 7) == 0));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    model_en = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 200 && got_q.size() < exp_q.size(); n++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rand_word%0d", i), {10'd0, got_q[i]}, {10'd0, exp_q[i]});
    check("rand_end_cnt", 32'(dut.cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
